// File: rtl/serial_to_parallel_buffered_pkg.sv
// serial_to_parallel_buffered_pkg: shared sizing helper for the deserializer and its FIFO
package serial_to_parallel_buffered_pkg;
  function automatic int min1_clog2(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_to_parallel_buffered_word_fifo.sv
// word_fifo: small word FIFO that accepts a push while full when a pop happens in the same cycle
module word_fifo
  import serial_to_parallel_buffered_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] head_data
);
  localparam int PW = min1_clog2(depth);
  localparam int NW = min1_clog2(depth + 1);
  logic [width-1:0] mem_q [depth];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [NW-1:0] n_q, n_d;
  logic do_push, do_pop;
  assign empty = n_q == '0;
  assign full = n_q == NW'(depth);
  assign head_data = empty ? '0 : mem_q[rd_q];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_comb begin
    rd_d = do_pop ? (rd_q == PW'(depth - 1) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d = do_push ? (wr_q == PW'(depth - 1) ? '0 : wr_q + 1'b1) : wr_q;
    n_d = (do_push && !do_pop) ? n_q + 1'b1 : (do_pop && !do_push) ? n_q - 1'b1 : n_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      n_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      n_q <= n_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/serial_to_parallel_buffered.sv
// serial_to_parallel_buffered: LSB-first bit stream to words, buffered behind a valid/ready FIFO with drop stats
module serial_to_parallel_buffered
  import serial_to_parallel_buffered_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 2,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_valid,
  input  logic                 serial_data,
  input  logic                 parallel_ready,
  input  logic                 clear_stats,
  output logic                 parallel_valid,
  output logic [width-1:0]     parallel_data,
  output logic                 busy,
  output logic                 overflow,
  output logic [cnt_width-1:0] drop_count
);
  localparam int CW = min1_clog2(width);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [width-2:0] sh_q, sh_d;
  logic ovf_q, ovf_d;
  logic [cnt_width-1:0] drop_q, drop_d;
  logic last, full, empty, pop, drop;
  assign last = serial_valid && cnt_q == CW'(width - 1);
  assign pop = !empty && parallel_ready;
  assign drop = last && full && !pop;
  always_comb begin
    cnt_d = serial_valid ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    sh_d = sh_q;
    if (serial_valid && !last) sh_d[cnt_q] = serial_data;
    ovf_d = drop || (ovf_q && !clear_stats);
    // a drop in the same cycle as a clear leaves exactly one counted drop
    drop_d = drop ? (clear_stats ? cnt_width'(1) : (&drop_q ? drop_q : drop_q + 1'b1))
                  : (clear_stats ? '0 : drop_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
  end
  word_fifo #(.width(width), .depth(depth)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(last),
    .push_data({serial_data, sh_q}),
    .pop(pop),
    .full(full),
    .empty(empty),
    .head_data(parallel_data)
  );
  assign parallel_valid = !empty;
  assign busy = cnt_q != '0;
  assign overflow = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_serial_to_parallel_buffered.sv
// tb_serial_to_parallel_buffered: table vectors, directed corner sequences and random traffic against a queue model
module tb_serial_to_parallel_buffered;
  localparam int W = 8, D = 2, C = 8;
  logic clk = 0, rst = 1, sv = 0, sd = 0, rdy = 0, clr = 0;
  logic pv, busy, ovf;
  logic [W-1:0] pd;
  logic [C-1:0] dc;
  int checks = 0, failures = 0;

  serial_to_parallel_buffered #(.width(W), .depth(D), .cnt_width(C)) dut (
    .clk(clk), .rst(rst), .serial_valid(sv), .serial_data(sd),
    .parallel_ready(rdy), .clear_stats(clr), .parallel_valid(pv),
    .parallel_data(pd), .busy(busy), .overflow(ovf), .drop_count(dc)
  );

  always #5 clk = ~clk;

  int unsigned mq[$];
  int m_bits[W];
  int m_k = 0, m_drop = 0;
  bit m_ovf = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int word;
    bit popped, dropped;
    if (rst) begin
      mq.delete();
      m_k = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    popped = (mq.size() > 0) && rdy;
    if (popped) void'(mq.pop_front());
    dropped = 0;
    if (sv) begin
      m_bits[m_k] = sd;
      if (m_k == W - 1) begin
        word = 0;
        for (int i = 0; i < W; i++) word += m_bits[i] << i;
        if (mq.size() < D) mq.push_back(word);
        else dropped = 1;
      end
      m_k = (m_k + 1) % W;
    end
    if (clr) begin m_ovf = 0; m_drop = 0; end
    if (dropped) begin
      m_ovf = 1;
      m_drop = (m_drop + 1 > (1 << C) - 1) ? (1 << C) - 1 : m_drop + 1;
    end
  endtask

  task automatic step(input logic v, input logic b, input logic r, input logic c);
    sv = v; sd = b; rdy = r; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", int'(pv), (mq.size() > 0) ? 1 : 0);
    chk("data", int'(pd), (mq.size() > 0) ? int'(mq[0]) : 0);
    chk("busy", int'(busy), (m_k != 0) ? 1 : 0);
    chk("overflow", int'(ovf), int'(m_ovf));
    chk("drop_count", int'(dc), m_drop);
  endtask

  task automatic do_reset();
    rst = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 0;
    chk("rst_valid", int'(pv), 0);
    chk("rst_data", int'(pd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_drops", int'(dc), 0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r, input logic last_r,
                           input logic last_clr, input int maxgap);
    for (int i = 0; i < W; i++) begin
      int g = (maxgap > 0) ? int'($urandom_range(maxgap)) : 0;
      for (int j = 0; j < g; j++) step(0, 0, r, 0);
      step(1, w[i], (i == W - 1) ? last_r : r, (i == W - 1) ? last_clr : 1'b0);
    end
  endtask

  typedef struct {
    logic v, b, r;
    logic ev;
    logic [W-1:0] ed;
    logic eb;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 1, 1, 0, 8'h00, 1};
    tbl[1] = '{1, 0, 1, 0, 8'h00, 1};
    tbl[2] = '{1, 1, 1, 0, 8'h00, 1};
    tbl[3] = '{1, 0, 1, 0, 8'h00, 1};
    tbl[4] = '{1, 0, 1, 0, 8'h00, 1};
    tbl[5] = '{1, 1, 1, 0, 8'h00, 1};
    tbl[6] = '{1, 0, 1, 0, 8'h00, 1};
    tbl[7] = '{1, 1, 1, 1, 8'hA5, 0};
    tbl[8] = '{0, 0, 1, 0, 8'h00, 0};
    tbl[9] = '{0, 0, 1, 0, 8'h00, 0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].r, 0);
      chk("t1_valid", int'(pv), int'(tbl[i].ev));
      chk("t1_data", int'(pd), int'(tbl[i].ed));
      chk("t1_busy", int'(busy), int'(tbl[i].eb));
    end

    send_word(8'h3C, 1, 1, 0, 3);
    chk("t2_valid", int'(pv), 1);
    chk("t2_data", int'(pd), 8'h3C);
    step(0, 0, 1, 0);
    chk("t2_empty", int'(pv), 0);

    send_word(8'h11, 0, 0, 0, 0);
    send_word(8'h22, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t3_hold_valid", int'(pv), 1);
    chk("t3_hold_data", int'(pd), 8'h11);
    step(0, 0, 1, 0);
    chk("t3_second", int'(pd), 8'h22);
    step(0, 0, 1, 0);
    chk("t3_empty_valid", int'(pv), 0);
    chk("t3_empty_data", int'(pd), 0);

    send_word(8'h11, 0, 0, 0, 0);
    send_word(8'h22, 0, 0, 0, 0);
    send_word(8'h33, 0, 0, 0, 0);
    chk("t4_ovf", int'(ovf), 1);
    chk("t4_drops", int'(dc), 1);
    step(0, 0, 1, 0);
    chk("t4_drain1", int'(pd), 8'h22);
    step(0, 0, 1, 0);
    chk("t4_drain_end", int'(pv), 0);
    step(0, 0, 0, 1);
    chk("t4_clr_ovf", int'(ovf), 0);
    chk("t4_clr_drops", int'(dc), 0);

    send_word(8'h11, 0, 0, 0, 0);
    send_word(8'h22, 0, 0, 0, 0);
    send_word(8'h44, 0, 1, 0, 0);
    chk("t5_head", int'(pd), 8'h22);
    chk("t5_drops", int'(dc), 0);
    step(0, 0, 1, 0);
    chk("t5_next", int'(pd), 8'h44);
    step(0, 0, 1, 0);
    chk("t5_empty", int'(pv), 0);
    chk("t5_ovf", int'(ovf), 0);

    for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
    chk("t6_busy_mid", int'(busy), 1);
    do_reset();
    send_word(8'h5A, 1, 1, 0, 0);
    chk("t6_word", int'(pd), 8'h5A);
    step(0, 0, 1, 0);
    for (int i = 0; i < D + 256; i++) send_word(W'($urandom), 0, 0, 0, 0);
    chk("t6_sat", int'(dc), 8'hFF);
    chk("t6_sat_ovf", int'(ovf), 1);
    send_word(8'h77, 0, 0, 1, 0);
    chk("t6_clr_drop", int'(dc), 1);
    chk("t6_clr_drop_ovf", int'(ovf), 1);
    step(0, 0, 0, 1);
    chk("t6_clr", int'(dc), 0);

    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 99) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel_buffered.md
Name: serial_to_parallel_buffered

Overview:
- Downstream stage for the parallel-to-serial block. Consumes its LSB-first `serial_valid`/`serial_data` bit stream and reassembles `width`-bit words.
- Completed words are held in a small output FIFO and presented through a valid/ready handshake, so the deserializer keeps accepting bits while the consumer stalls.
- Words that arrive while the FIFO is full are dropped and counted. The serial side has no backpressure.

Parameters:
- width, 8, word width in bits; must be >= 2.
- depth, 2, output FIFO depth in words; must be >= 1; not required to be a power of two.
- cnt_width, 8, width of the dropped-word counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- serial_valid  input  1  `serial_data` carries a valid bit this cycle.
- serial_data  input  1  data bit; the first bit of a word is its LSB.
- parallel_ready  input  1  consumer accepts the head word this cycle.
- clear_stats  input  1  one-cycle pulse; clears `overflow` and `drop_count`.
- parallel_valid  output  1  FIFO non-empty; head word presented.
- parallel_data  output  width  head word; 0 when FIFO empty.
- busy  output  1  partial word in progress (bit counter != 0).
- overflow  output  1  sticky: at least one word dropped since reset or clear.
- drop_count  output  cnt_width  number of dropped words; saturates at all-ones.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset state: bit counter 0, shift register 0, FIFO empty, parallel_valid=0, parallel_data=0, busy=0, overflow=0, drop_count=0.
- Bit counter range 0..width-1.
  - Advances only on cycles with serial_valid=1.
  - Wraps from width-1 to 0.
  - Idle cycles (serial_valid=0) hold all state; gaps between bits are legal.
- Bit k of a word (k = counter value) is stored at position k.
- Word complete: serial_valid=1 with counter=width-1. The complete word is {serial_data, shift_reg[width-2:0]} and is pushed to the FIFO in that same cycle.
- Latency: parallel_valid rises the cycle after the last bit is sampled, when the FIFO was empty.
- Pop occurs when parallel_valid && parallel_ready.
  - Head advances next cycle.
  - Back-to-back pops are allowed, one word per cycle.
- parallel_data depends only on FIFO state, never combinationally on inputs.
- Push while FIFO full and no pop in the same cycle:
  - Word dropped; FIFO contents unchanged.
  - overflow<=1 and drop_count<=drop_count+1, saturating.
- Push while FIFO full with a pop in the same cycle: push accepted, nothing dropped, occupancy unchanged.
- Push and pop on an empty FIFO: impossible, since parallel_valid=0 when empty.
- clear_stats=1: overflow<=0, drop_count<=0.
  - If a drop occurs in the same cycle, the drop wins: overflow<=1, drop_count<=1.
- busy is registered-state derived: busy = (counter != 0).
- Reset mid-word: partial bits are discarded and alignment restarts at bit 0 on the next serial_valid. Reset also discards FIFO contents.
- Word alignment comes solely from counting since reset. There is no in-band resync.

Decomposition:
- No shared package required. Local constants: counter width = $clog2(width) and FIFO pointer width = $clog2(depth), with a minimum of 1 each.
- One natural sub-module: word_fifo.
  - Parameters: width, depth.
  - Ports: push, push_data, pop, full, empty, head_data.
  - Must accept push while full when pop is asserted in the same cycle.
- Top level holds the bit counter, shift register, drop logic and statistics.

Test Plan (width=8, depth=2, cnt_width=8):
1. Reset, parallel_ready=1, send 0xA5 as 8 consecutive bits LSB first (1,0,1,0,0,1,0,1) -> parallel_valid=1 for exactly one cycle, the cycle after bit 8, with parallel_data=0xA5; busy=1 from after bit 1 until counter wraps.
2. Send 0x3C with 0-3 random idle cycles between bits -> single word 0x3C; no state change during idle cycles.
3. parallel_ready=0, send 0x11 then 0x22 -> parallel_valid stays 1 with data 0x11; raise ready -> 0x11 then 0x22 on consecutive cycles, then parallel_valid=0, parallel_data=0.
4. parallel_ready=0, send 0x11, 0x22, 0x33 -> overflow=1 and drop_count=1 the cycle after the 24th bit; drain yields only 0x11, 0x22. Then pulse clear_stats -> overflow=0, drop_count=0.
5. FIFO full (0x11, 0x22), pulse parallel_ready on the cycle of the last bit of 0x44 -> no drop; drain yields 0x22, 0x44; drop_count stays 0.
6. Assert rst after 3 bits of 0xFF, then send 0x5A -> output 0x5A exactly; 256 forced drops -> drop_count saturates at 0xFF.
